// File: rtl/estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// estacao_reserva_add
// Reservation station for an ADD/SUB functional unit (Tomasulo style).
// The station holds one instruction. It waits for missing operands on the
// common data bus (CDB), runs for EXEC_LATENCY cycles, and then asks the CDB
// arbiter for permission to broadcast its result.
//
// Optional feature, compile-time macro ESTACAO_CDB_BYPASS_EN:
//   When defined, the station also watches the CDB in the cycle an
//   instruction is dispatched. A broadcast that matches an incoming tag in
//   that same cycle is captured immediately.
//   When undefined, such a broadcast is not seen. The dispatch unit must make
//   sure it never happens.
// ---------------------------------------------------------------------------
module estacao_reserva_add #(
  parameter logic [2:0] STATION_ID   = 3'd1,
  parameter int         EXEC_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  input  logic [2:0]  Opcode,
  input  logic [15:0] Vj,
  input  logic [15:0] Vk,
  input  logic [2:0]  Qj,
  input  logic [2:0]  Qk,
  input  logic        CDB_Valid,
  input  logic [2:0]  CDB_Tag,
  input  logic [15:0] CDB_Data,
  input  logic        CDB_Grant,
  output logic        CDB_Req,
  output logic [2:0]  Result_Tag,
  output logic [15:0] Result_Data,
  output logic        Ready,
  output logic        Busy
);

  // An operand that is still waiting for its producer holds this marker value
  // until real data arrives.
  localparam logic [15:0] PENDING_MARK = 16'hFFF0;
  localparam logic [3:0]  LAT          = 4'(EXEC_LATENCY);
  localparam logic [2:0]  OP_SUB       = 3'b001;

  typedef enum logic [1:0] {
    LIVRE,
    ESPERA,
    EXEC,
    ESCRITA
  } state_t;

  state_t      r_state;
  logic [2:0]  r_opcode;
  logic [15:0] r_vj;
  logic [15:0] r_vk;
  logic [2:0]  r_qj;
  logic [2:0]  r_qk;
  logic [3:0]  r_count;
  logic        r_cdbReq;
  logic [2:0]  r_resultTag;
  logic [15:0] r_resultData;
  logic        r_ready;
  logic        r_busy;

  logic        w_cdbUsable;
  logic        w_hitJ;
  logic        w_hitK;
  logic [2:0]  w_nextQj;
  logic [2:0]  w_nextQk;
  logic        w_dispHitJ;
  logic        w_dispHitK;
  logic [2:0]  w_dispQj;
  logic [2:0]  w_dispQk;
  logic [15:0] w_dispVj;
  logic [15:0] w_dispVk;
  logic [15:0] w_result;

  // A broadcast is only useful if it carries a real tag from another station.
  // Our own result tag is never treated as an operand source.
  assign w_cdbUsable = CDB_Valid && (CDB_Tag != 3'd0) && (CDB_Tag != STATION_ID);

  // Operand capture while waiting. One broadcast can satisfy both operands.
  assign w_hitJ   = w_cdbUsable && (r_qj != 3'd0) && (CDB_Tag == r_qj);
  assign w_hitK   = w_cdbUsable && (r_qk != 3'd0) && (CDB_Tag == r_qk);
  assign w_nextQj = w_hitJ ? 3'd0 : r_qj;
  assign w_nextQk = w_hitK ? 3'd0 : r_qk;

`ifdef ESTACAO_CDB_BYPASS_EN
  // Watch the CDB during dispatch so that a result produced in the same
  // cycle is captured.
  assign w_dispHitJ = w_cdbUsable && (Qj != 3'd0) && (CDB_Tag == Qj);
  assign w_dispHitK = w_cdbUsable && (Qk != 3'd0) && (CDB_Tag == Qk);
`else
  // The CDB is ignored during dispatch. Incoming tags are stored as they are.
  assign w_dispHitJ = 1'b0;
  assign w_dispHitK = 1'b0;
`endif

  // Effective tags and values captured on the dispatch edge.
  assign w_dispQj = w_dispHitJ ? 3'd0 : Qj;
  assign w_dispQk = w_dispHitK ? 3'd0 : Qk;
  assign w_dispVj = w_dispHitJ ? CDB_Data : ((Qj == 3'd0) ? Vj : PENDING_MARK);
  assign w_dispVk = w_dispHitK ? CDB_Data : ((Qk == 3'd0) ? Vk : PENDING_MARK);

  // SUB for opcode 001. Every other opcode adds. Results wrap modulo 2^16.
  assign w_result = (r_opcode == OP_SUB) ? (r_vj - r_vk) : (r_vj + r_vk);

  // Station controller: the state, the latched operands and all outputs
  // change together on the clock edge.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state      <= LIVRE;
      r_opcode     <= 3'd0;
      r_vj         <= PENDING_MARK;
      r_vk         <= PENDING_MARK;
      r_qj         <= 3'd0;
      r_qk         <= 3'd0;
      r_count      <= 4'd0;
      r_cdbReq     <= 1'b0;
      r_resultTag  <= 3'd0;
      r_resultData <= 16'h0000;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        LIVRE: begin
          if (Enable) begin
            r_opcode <= Opcode;
            r_vj     <= w_dispVj;
            r_vk     <= w_dispVk;
            r_qj     <= w_dispQj;
            r_qk     <= w_dispQk;
            r_ready  <= 1'b0;
            r_busy   <= 1'b1;
            if ((w_dispQj == 3'd0) && (w_dispQk == 3'd0)) begin
              r_state <= EXEC;
              r_count <= LAT;
            end else begin
              r_state <= ESPERA;
            end
          end
        end

        ESPERA: begin
          if (w_hitJ) begin
            r_vj <= CDB_Data;
            r_qj <= 3'd0;
          end
          if (w_hitK) begin
            r_vk <= CDB_Data;
            r_qk <= 3'd0;
          end
          if ((w_nextQj == 3'd0) && (w_nextQk == 3'd0)) begin
            r_state <= EXEC;
            r_count <= LAT;
          end
        end

        EXEC: begin
          if (r_count <= 4'd1) begin
            r_state      <= ESCRITA;
            r_count      <= 4'd0;
            r_cdbReq     <= 1'b1;
            r_resultTag  <= STATION_ID;
            r_resultData <= w_result;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end

        ESCRITA: begin
          if (CDB_Grant) begin
            r_state      <= LIVRE;
            r_cdbReq     <= 1'b0;
            r_resultTag  <= 3'd0;
            r_resultData <= 16'h0000;
            r_ready      <= 1'b1;
            r_busy       <= 1'b0;
          end
        end

        default: begin
          r_state  <= LIVRE;
          r_cdbReq <= 1'b0;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

  assign CDB_Req     = r_cdbReq;
  assign Result_Tag  = r_resultTag;
  assign Result_Data = r_resultData;
  assign Ready       = r_ready;
  assign Busy        = r_busy;

endmodule

// File: tb/tb_estacao_reserva_add.sv
// ---------------------------------------------------------------------------
// tb_estacao_reserva_add
// Testbench for the ADD/SUB reservation station, driven by directed vectors.
// Expected results go into a queue when an instruction is dispatched.
// A separate monitor process checks each new CDB request against that queue.
// ---------------------------------------------------------------------------
module tb_estacao_reserva_add;

  localparam logic [2:0] STATION = 3'd1;
  localparam int         LAT     = 2;

  logic        Clock;
  logic        Reset;
  logic        Enable;
  logic [2:0]  Opcode;
  logic [15:0] Vj;
  logic [15:0] Vk;
  logic [2:0]  Qj;
  logic [2:0]  Qk;
  logic        CDB_Valid;
  logic [2:0]  CDB_Tag;
  logic [15:0] CDB_Data;
  logic        CDB_Grant;
  logic        CDB_Req;
  logic [2:0]  Result_Tag;
  logic [15:0] Result_Data;
  logic        Ready;
  logic        Busy;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [15:0] expQ[$];
  logic [15:0] expData;
  bit          prevReq = 1'b0;

  estacao_reserva_add #(
    .STATION_ID  (STATION),
    .EXEC_LATENCY(LAT)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Enable     (Enable),
    .Opcode     (Opcode),
    .Vj         (Vj),
    .Vk         (Vk),
    .Qj         (Qj),
    .Qk         (Qk),
    .CDB_Valid  (CDB_Valid),
    .CDB_Tag    (CDB_Tag),
    .CDB_Data   (CDB_Data),
    .CDB_Grant  (CDB_Grant),
    .CDB_Req    (CDB_Req),
    .Result_Tag (Result_Tag),
    .Result_Data(Result_Data),
    .Ready      (Ready),
    .Busy       (Busy)
  );

  // Free-running clock with a 10-unit period.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a rising CDB request pops one expected result from
  // the queue and compares it.
  always @(negedge Clock) begin
    if (CDB_Req === 1'b1 && !prevReq) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_req", 16'd1, 16'd0);
      end else begin
        expData = expQ.pop_front();
        checkOutput("result_data", Result_Data, expData);
        checkOutput("result_tag", 16'(Result_Tag), 16'(STATION));
      end
    end
    prevReq = (CDB_Req === 1'b1);
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                               input logic [2:0] qj, input logic [2:0] qk);
    @(negedge Clock);
    Opcode = op;
    Vj     = vj;
    Vk     = vk;
    Qj     = qj;
    Qk     = qk;
    Enable = 1'b1;
    @(posedge Clock);
    #1;
    Enable = 1'b0;
  endtask

  task automatic cdbPulse(input logic [2:0] tag, input logic [15:0] data);
    @(negedge Clock);
    CDB_Valid = 1'b1;
    CDB_Tag   = tag;
    CDB_Data  = data;
    @(posedge Clock);
    #1;
    CDB_Valid = 1'b0;
    CDB_Tag   = 3'd0;
    CDB_Data  = 16'h0000;
  endtask

  // Call right after the edge that enters EXEC. The request must go high
  // exactly LAT edges later.
  task automatic checkExecTiming();
    checkOutput("exec_req_low", 16'(CDB_Req), 16'd0);
    checkOutput("exec_ready_low", 16'(Ready), 16'd0);
    repeat (LAT - 1) begin
      nextCycle();
      checkOutput("exec_req_low", 16'(CDB_Req), 16'd0);
    end
    nextCycle();
    checkOutput("write_req_high", 16'(CDB_Req), 16'd1);
  endtask

  task automatic grantResult();
    @(negedge Clock);
    CDB_Grant = 1'b1;
    @(posedge Clock);
    #1;
    CDB_Grant = 1'b0;
    checkOutput("grant_ready", 16'(Ready), 16'd1);
    checkOutput("grant_busy", 16'(Busy), 16'd0);
    checkOutput("grant_req_low", 16'(CDB_Req), 16'd0);
  endtask

  // Main directed sequence.
  initial begin
    Reset = 1'b1; Enable = 1'b0; Opcode = 3'd0; Vj = 16'h0; Vk = 16'h0;
    Qj = 3'd0; Qk = 3'd0; CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
    CDB_Grant = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("rst_ready", 16'(Ready), 16'd1);
    checkOutput("rst_busy", 16'(Busy), 16'd0);
    checkOutput("rst_req", 16'(CDB_Req), 16'd0);
    checkOutput("rst_tag", 16'(Result_Tag), 16'd0);
    checkOutput("rst_data", Result_Data, 16'h0000);
    Reset = 1'b0;

    // ADD 5 + 7 = 12 with both operands present.
    expQ.push_back(16'd12);
    applyStimulus(3'b000, 16'd5, 16'd7, 3'd0, 3'd0);
    checkOutput("add_busy", 16'(Busy), 16'd1);
    checkExecTiming();
    grantResult();

    // Vj waits for tag 2. A broadcast with tag 5 does not match; tag 2 with
    // data 4 arrives three cycles after dispatch. Result 4 + 10 = 14.
    expQ.push_back(16'd14);
    applyStimulus(3'b000, 16'h0000, 16'd10, 3'd2, 3'd0);
    nextCycle();
    cdbPulse(3'd5, 16'h0066);
    checkOutput("wait_req_low", 16'(CDB_Req), 16'd0);
    checkOutput("wait_ready_low", 16'(Ready), 16'd0);
    cdbPulse(3'd2, 16'd4);
    checkExecTiming();
    grantResult();

    // Both operands wait on tag 3. One broadcast of 6 resolves both: 6 + 6 = 12.
    expQ.push_back(16'd12);
    applyStimulus(3'b000, 16'hAAAA, 16'hBBBB, 3'd3, 3'd3);
    nextCycle();
    cdbPulse(3'd3, 16'd6);
    checkExecTiming();
    grantResult();

    // Grant is withheld for five cycles. The result must stay stable, and an
    // Enable during this window must be ignored. 100 + 200 = 0x012C.
    expQ.push_back(16'h012C);
    applyStimulus(3'b000, 16'd100, 16'd200, 3'd0, 3'd0);
    checkExecTiming();
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      Enable = (i == 1);
      Opcode = 3'b001; Vj = 16'd9; Vk = 16'd1; Qj = 3'd0; Qk = 3'd0;
      @(posedge Clock);
      #1;
      checkOutput("hold_req", 16'(CDB_Req), 16'd1);
      checkOutput("hold_data", Result_Data, 16'h012C);
      checkOutput("hold_tag", 16'(Result_Tag), 16'(STATION));
    end
    Enable = 1'b0;
    grantResult();
    repeat (4) begin
      nextCycle();
      checkOutput("idle_after_ignored_en", 16'(CDB_Req), 16'd0);
    end

    // SUB 3 - 5 wraps around to 0xFFFE.
    expQ.push_back(16'hFFFE);
    applyStimulus(3'b001, 16'd3, 16'd5, 3'd0, 3'd0);
    checkExecTiming();
    grantResult();

    // Reset in the middle of EXEC drops the instruction immediately.
    applyStimulus(3'b000, 16'd1, 16'd2, 3'd0, 3'd0);
    #2;
    Reset = 1'b1;
    #1;
    checkOutput("midrst_ready", 16'(Ready), 16'd1);
    checkOutput("midrst_busy", 16'(Busy), 16'd0);
    checkOutput("midrst_req", 16'(CDB_Req), 16'd0);
    checkOutput("midrst_data", Result_Data, 16'h0000);
    @(negedge Clock);
    Reset = 1'b0;
    repeat (5) begin
      nextCycle();
      checkOutput("post_rst_req", 16'(CDB_Req), 16'd0);
    end

`ifdef ESTACAO_CDB_BYPASS_EN
    // Same-cycle CDB capture at dispatch: Vj becomes 9, so 9 + 1 = 10.
    expQ.push_back(16'd10);
    @(negedge Clock);
    Opcode = 3'b000; Vj = 16'h1234; Vk = 16'd1; Qj = 3'd2; Qk = 3'd0;
    Enable = 1'b1; CDB_Valid = 1'b1; CDB_Tag = 3'd2; CDB_Data = 16'd9;
    @(posedge Clock);
    #1;
    Enable = 1'b0; CDB_Valid = 1'b0; CDB_Tag = 3'd0; CDB_Data = 16'h0;
    checkExecTiming();
    grantResult();
`endif

    repeat (2) nextCycle();
    checkOutput("queue_empty", 16'(expQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
